// File: rtl/maq_mh.sv
// maq_mh: minutes/hours stage of the clock datapath. Counts BCD minutes
//   (00-59) and hours (00-23) on qualified minute carries, provides a
//   button-driven RUN -> SET_HR -> SET_MIN time-set machine, a blink phase
//   for the field being set, and a one-clock day-rollover pulse.
// Latency: carries update the digits on the sampling edge; a button rise
//   before edge N takes effect at edge N+2. Backpressure: none, free running.
// Ports: maqmh_clock/maqmh_reset (async, active-high); enable_1hz, inc_minuto
//   carry inputs; btn_mode/btn_inc async buttons; BCD digit outputs, set
//   flags, blink, inc_dia pulse, and maqmh_pm when MAQMH_AMPM_EN is defined
//   (12-hour display; internal counting stays 0-23).
module maq_mh (
  input  logic       maqmh_clock,
  input  logic       maqmh_reset,
  input  logic       enable_1hz,
  input  logic       inc_minuto,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] maqmh_min_lsd,
  output logic [2:0] maqmh_min_msd,
  output logic [3:0] maqmh_hr_lsd,
  output logic [1:0] maqmh_hr_msd,
  output logic       maqmh_set_hr,
  output logic       maqmh_set_min,
  output logic       maqmh_blink,
  output logic       maqmh_inc_dia
`ifdef MAQMH_AMPM_EN
  ,
  output logic       maqmh_pm
`endif
);

  typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} state_t;

  state_t     state_q, state_n;
  logic       mode_s1, mode_s2, mode_d;
  logic       inc_s1, inc_s2, inc_d;
  logic [3:0] min_lsd_q, min_lsd_n;
  logic [2:0] min_msd_q, min_msd_n;
  logic [3:0] hr_lsd_q, hr_lsd_n;
  logic [1:0] hr_msd_q, hr_msd_n;
  logic       set_hr_q, set_min_q, blink_q, inc_dia_q;
  logic       mode_evt, inc_evt, set_inc, carry;
  logic       min_at_59, hr_at_23, min_step, hr_step;

  // Rising edge of the synchronized level; a held button gives one event.
  assign mode_evt = mode_s2 && !mode_d;
  assign inc_evt  = inc_s2 && !inc_d;

  always_comb begin
    carry     = (state_q == RUN) && enable_1hz && inc_minuto;
    // Mode wins over a coincident increment.
    set_inc   = inc_evt && !mode_evt;
    min_at_59 = (min_msd_q == 3'd5) && (min_lsd_q == 4'd9);
    hr_at_23  = (hr_msd_q == 2'd2) && (hr_lsd_q == 4'd3);
    min_step  = carry || ((state_q == SET_MIN) && set_inc);
    // Set-mode minute increments never carry into hours.
    hr_step   = (carry && min_at_59) || ((state_q == SET_HR) && set_inc);

    min_lsd_n = min_lsd_q;
    min_msd_n = min_msd_q;
    if (min_step) begin
      if (min_lsd_q == 4'd9) begin
        min_lsd_n = 4'd0;
        min_msd_n = (min_msd_q == 3'd5) ? 3'd0 : min_msd_q + 3'd1;
      end else begin
        min_lsd_n = min_lsd_q + 4'd1;
      end
    end

    hr_lsd_n = hr_lsd_q;
    hr_msd_n = hr_msd_q;
    if (hr_step) begin
      if (hr_at_23) begin
        hr_lsd_n = 4'd0;
        hr_msd_n = 2'd0;
      end else if (hr_lsd_q == 4'd9) begin
        hr_lsd_n = 4'd0;
        hr_msd_n = hr_msd_q + 2'd1;
      end else begin
        hr_lsd_n = hr_lsd_q + 4'd1;
      end
    end

    state_n = state_q;
    if (mode_evt) begin
      case (state_q)
        RUN:     state_n = SET_HR;
        SET_HR:  state_n = SET_MIN;
        default: state_n = RUN;
      endcase
    end
  end

`ifdef MAQMH_AMPM_EN
  logic [4:0] hr_bin_n, disp_bin_n;
  logic [3:0] disp_lsd_q;
  logic [1:0] disp_msd_q;
  logic       pm_q;

  // 24h -> 12h conversion of the next hour, so the registered display
  // changes on the same edge as the internal count.
  always_comb begin
    hr_bin_n = ({3'b000, hr_msd_n} * 5'd10) + {1'b0, hr_lsd_n};
    if (hr_bin_n == 5'd0)
      disp_bin_n = 5'd12;
    else if (hr_bin_n > 5'd12)
      disp_bin_n = hr_bin_n - 5'd12;
    else
      disp_bin_n = hr_bin_n;
  end

  always_ff @(posedge maqmh_clock or posedge maqmh_reset) begin
    if (maqmh_reset) begin
      disp_lsd_q <= 4'd2;
      disp_msd_q <= 2'd1;
      pm_q       <= 1'b0;
    end else begin
      disp_msd_q <= (disp_bin_n >= 5'd10) ? 2'd1 : 2'd0;
      disp_lsd_q <= (disp_bin_n >= 5'd10) ? 4'(disp_bin_n - 5'd10) : 4'(disp_bin_n);
      pm_q       <= (hr_bin_n >= 5'd12);
    end
  end

  assign maqmh_hr_lsd = disp_lsd_q;
  assign maqmh_hr_msd = disp_msd_q;
  assign maqmh_pm     = pm_q;
`else
  assign maqmh_hr_lsd = hr_lsd_q;
  assign maqmh_hr_msd = hr_msd_q;
`endif

  always_ff @(posedge maqmh_clock or posedge maqmh_reset) begin
    if (maqmh_reset) begin
      state_q   <= RUN;
      mode_s1   <= 1'b0;
      mode_s2   <= 1'b0;
      mode_d    <= 1'b0;
      inc_s1    <= 1'b0;
      inc_s2    <= 1'b0;
      inc_d     <= 1'b0;
      min_lsd_q <= 4'd0;
      min_msd_q <= 3'd0;
      hr_lsd_q  <= 4'd0;
      hr_msd_q  <= 2'd0;
      set_hr_q  <= 1'b0;
      set_min_q <= 1'b0;
      blink_q   <= 1'b0;
      inc_dia_q <= 1'b0;
    end else begin
      mode_s1   <= btn_mode;
      mode_s2   <= mode_s1;
      mode_d    <= mode_s2;
      inc_s1    <= btn_inc;
      inc_s2    <= inc_s1;
      inc_d     <= inc_s2;
      state_q   <= state_n;
      min_lsd_q <= min_lsd_n;
      min_msd_q <= min_msd_n;
      hr_lsd_q  <= hr_lsd_n;
      hr_msd_q  <= hr_msd_n;
      set_hr_q  <= (state_n == SET_HR);
      set_min_q <= (state_n == SET_MIN);
      if (state_n != state_q)
        blink_q <= 1'b0;
      else if (state_q == RUN)
        blink_q <= 1'b0;
      else if (enable_1hz)
        blink_q <= ~blink_q;
      // Only a RUN carry out of 23:59 marks a new day.
      inc_dia_q <= carry && min_at_59 && hr_at_23;
    end
  end

  assign maqmh_min_lsd = min_lsd_q;
  assign maqmh_min_msd = min_msd_q;
  assign maqmh_set_hr  = set_hr_q;
  assign maqmh_set_min = set_min_q;
  assign maqmh_blink   = blink_q;
  assign maqmh_inc_dia = inc_dia_q;

endmodule

// File: tb/tb_maq_mh.sv
// tb_maq_mh: self-checking bench for maq_mh. A time-of-day model in minutes
//   plus a mode index predicts the outputs for directed and random sequences.
module tb_maq_mh;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable_1hz = 1'b0, inc_minuto = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [3:0] min_lsd, hr_lsd;
  logic [2:0] min_msd;
  logic [1:0] hr_msd;
  logic       set_hr, set_min, blink, inc_dia;
`ifdef MAQMH_AMPM_EN
  logic       pm;
`endif

  maq_mh dut (
    .maqmh_clock  (clk),
    .maqmh_reset  (rst),
    .enable_1hz   (enable_1hz),
    .inc_minuto   (inc_minuto),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .maqmh_min_lsd(min_lsd),
    .maqmh_min_msd(min_msd),
    .maqmh_hr_lsd (hr_lsd),
    .maqmh_hr_msd (hr_msd),
    .maqmh_set_hr (set_hr),
    .maqmh_set_min(set_min),
    .maqmh_blink  (blink),
    .maqmh_inc_dia(inc_dia)
`ifdef MAQMH_AMPM_EN
    ,
    .maqmh_pm     (pm)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  // Model: minutes since midnight, mode 0=RUN 1=SET_HR 2=SET_MIN, blink, day pulse.
  int m_time = 0;
  int m_state = 0;
  bit m_blink = 1'b0;
  bit m_dia = 1'b0;

  function automatic int disp_hour(input int h);
`ifdef MAQMH_AMPM_EN
    if (h == 0) return 12;
    if (h > 12) return h - 12;
    return h;
`else
    return h;
`endif
  endfunction

  function automatic int obs_hr();
    return int'(hr_msd) * 10 + int'(hr_lsd);
  endfunction

  function automatic int obs_min();
    return int'(min_msd) * 10 + int'(min_lsd);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Button pulse: rise, hold 3 clocks (event lands at the 3rd edge), release 3 clocks.
  task automatic press(input bit m, input bit i);
    btn_mode = m;
    btn_inc  = i;
    repeat (3) tick();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (3) tick();
    m_dia = 1'b0;
    if (m) begin
      m_state = (m_state + 1) % 3;
      m_blink = 1'b0;
    end else if (i) begin
      if (m_state == 1) m_time = (((m_time / 60) + 1) % 24) * 60 + (m_time % 60);
      else if (m_state == 2) m_time = (m_time / 60) * 60 + ((m_time % 60) + 1) % 60;
    end
  endtask

  // One enable_1hz strobe with the given carry level.
  task automatic strobe(input bit lvl);
    enable_1hz = 1'b1;
    inc_minuto = lvl;
    tick();
    enable_1hz = 1'b0;
    inc_minuto = 1'b0;
    m_dia = 1'b0;
    if (lvl && m_state == 0) begin
      m_dia  = (m_time == 1439);
      m_time = (m_time + 1) % 1440;
    end
    if (m_state != 0) m_blink = ~m_blink;
  endtask

  task automatic set_time(input int h, input int mn);
    press(1'b1, 1'b0);
    while (m_time / 60 != h) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    while (m_time % 60 != mn) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    vectors++;
    if (obs_hr() !== disp_hour(0) || obs_min() !== 0 || set_hr !== 1'b0 || set_min !== 1'b0 ||
        blink !== 1'b0 || inc_dia !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_initial: got %0d:%0d flags %b%b%b%b, want %0d:0 flags 0000",
               obs_hr(), obs_min(), set_hr, set_min, blink, inc_dia, disp_hour(0));
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    set_time(13, 45);
    vectors++;
    if (obs_hr() !== disp_hour(13) || obs_min() !== 45) begin
      miscompares++;
      $display("FAIL preset_1345: got %0d:%0d want %0d:45", obs_hr(), obs_min(), disp_hour(13));
    end
    press(1'b1, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    m_time = 0; m_state = 0; m_blink = 1'b0; m_dia = 1'b0;
    vectors++;
    if (obs_hr() !== disp_hour(0) || obs_min() !== 0 || set_hr !== 1'b0 || set_min !== 1'b0 ||
        blink !== 1'b0 || inc_dia !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midset: got %0d:%0d flags %b%b%b%b, want %0d:0 flags 0000",
               obs_hr(), obs_min(), set_hr, set_min, blink, inc_dia, disp_hour(0));
    end
`ifdef MAQMH_AMPM_EN
    vectors++;
    if (pm !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pm: got %b want 0", pm);
    end
`endif
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_level_qualification();
    inc_minuto = 1'b1;
    repeat (500) tick();
    enable_1hz = 1'b1;
    tick();
    enable_1hz = 1'b0;
    repeat (499) tick();
    inc_minuto = 1'b0;
    m_time = m_time + 1;
    vectors++;
    if (obs_hr() !== disp_hour(0) || obs_min() !== 1) begin
      miscompares++;
      $display("FAIL level_qual: got %0d:%0d want %0d:1", obs_hr(), obs_min(), disp_hour(0));
    end
  endtask

  task automatic test_rollover();
    set_time(23, 59);
    strobe(1'b1);
    vectors++;
    if (obs_hr() !== disp_hour(0) || obs_min() !== 0 || inc_dia !== 1'b1) begin
      miscompares++;
      $display("FAIL rollover: got %0d:%0d dia %b want %0d:0 dia 1", obs_hr(), obs_min(), inc_dia, disp_hour(0));
    end
    tick();
    vectors++;
    if (inc_dia !== 1'b0) begin
      miscompares++;
      $display("FAIL dia_width: got %b want 0", inc_dia);
    end
  endtask

  task automatic test_set_mode();
    btn_mode = 1'b1;
    tick();
    tick();
    vectors++;
    if (set_hr !== 1'b0) begin
      miscompares++;
      $display("FAIL set_hr_early: got %b want 0 at edge N+1", set_hr);
    end
    tick();
    vectors++;
    if (set_hr !== 1'b1 || set_min !== 1'b0) begin
      miscompares++;
      $display("FAIL set_hr_edge: got hr %b min %b want 1 0 at edge N+2", set_hr, set_min);
    end
    btn_mode = 1'b0;
    repeat (3) tick();
    m_state = 1; m_blink = 1'b0;
    repeat (25) press(1'b0, 1'b1);
    vectors++;
    if (obs_hr() !== disp_hour(1) || obs_min() !== 0) begin
      miscompares++;
      $display("FAIL set_hr_25inc: got %0d:%0d want %0d:0", obs_hr(), obs_min(), disp_hour(1));
    end
    strobe(1'b1);
    vectors++;
    if (obs_hr() !== disp_hour(1) || obs_min() !== 0 || blink !== 1'b1) begin
      miscompares++;
      $display("FAIL carry_in_set: got %0d:%0d blink %b want %0d:0 blink 1", obs_hr(), obs_min(), blink, disp_hour(1));
    end
    strobe(1'b1);
    vectors++;
    if (blink !== 1'b0) begin
      miscompares++;
      $display("FAIL blink_toggle: got %b want 0", blink);
    end
    strobe(1'b1);
    press(1'b1, 1'b0);
    vectors++;
    if (set_min !== 1'b1 || set_hr !== 1'b0 || blink !== 1'b0) begin
      miscompares++;
      $display("FAIL to_set_min: got min %b hr %b blink %b want 1 0 0", set_min, set_hr, blink);
    end
    press(1'b1, 1'b0);
    vectors++;
    if (set_min !== 1'b0 || set_hr !== 1'b0 || blink !== 1'b0 || obs_hr() !== disp_hour(1) || obs_min() !== 0) begin
      miscompares++;
      $display("FAIL back_to_run: got flags %b%b%b time %0d:%0d want 000 %0d:0",
               set_hr, set_min, blink, obs_hr(), obs_min(), disp_hour(1));
    end
  endtask

  task automatic test_simultaneous();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    vectors++;
    if (set_hr !== 1'b0 || set_min !== 1'b0 || obs_hr() !== disp_hour(m_time / 60) || obs_min() !== m_time % 60) begin
      miscompares++;
      $display("FAIL mode_inc_same: got flags %b%b time %0d:%0d want 00 %0d:%0d",
               set_hr, set_min, obs_hr(), obs_min(), disp_hour(m_time / 60), m_time % 60);
    end
    set_time(10, 59);
    btn_mode = 1'b1;
    tick();
    tick();
    enable_1hz = 1'b1;
    inc_minuto = 1'b1;
    tick();
    enable_1hz = 1'b0;
    inc_minuto = 1'b0;
    btn_mode = 1'b0;
    m_time = 660; m_state = 1; m_blink = 1'b0;
    vectors++;
    if (obs_hr() !== disp_hour(11) || obs_min() !== 0 || set_hr !== 1'b1) begin
      miscompares++;
      $display("FAIL mode_with_carry: got %0d:%0d set_hr %b want %0d:0 set_hr 1",
               obs_hr(), obs_min(), set_hr, disp_hour(11));
    end
    repeat (3) tick();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
  endtask

  task automatic test_random();
    set_time(23, 57);
    for (int n = 0; n < 150; n++) begin
      int op;
      op = $urandom_range(0, 7);
      if (op <= 3) begin
        strobe(1'($urandom_range(0, 1)));
      end else if (op == 4) begin
        press(1'b1, 1'b0);
      end else if (op == 5) begin
        press(1'b0, 1'b1);
      end else begin
        inc_minuto = 1'b1;
        repeat ($urandom_range(1, 5)) tick();
        inc_minuto = 1'b0;
        m_dia = 1'b0;
      end
      vectors++;
      if (obs_hr() !== disp_hour(m_time / 60) || obs_min() !== m_time % 60 || inc_dia !== m_dia ||
          set_hr !== (m_state == 1) || set_min !== (m_state == 2) || blink !== m_blink) begin
        miscompares++;
        $display("FAIL random_%0d: got %0d:%0d dia %b hr %b min %b blink %b want %0d:%0d dia %b state %0d blink %b",
                 n, obs_hr(), obs_min(), inc_dia, set_hr, set_min, blink,
                 disp_hour(m_time / 60), m_time % 60, m_dia, m_state, m_blink);
      end
    end
    while (m_state != 0) press(1'b1, 1'b0);
  endtask

`ifdef MAQMH_AMPM_EN
  task automatic test_ampm();
    int hrs[4]  = '{0, 12, 13, 23};
    int disp[4] = '{12, 12, 1, 11};
    bit pms[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      set_time(hrs[k], 30);
      vectors++;
      if (obs_hr() !== disp[k] || pm !== pms[k] || obs_min() !== 30) begin
        miscompares++;
        $display("FAIL ampm_%0d: got %0d:%0d pm %b want %0d:30 pm %b", hrs[k], obs_hr(), obs_min(), pm, disp[k], pms[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_level_qualification();
    test_rollover();
    test_set_mode();
    test_simultaneous();
    test_random();
`ifdef MAQMH_AMPM_EN
    test_ampm();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
